// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one multi-cycle main memory between three requesters:
//   * D-cache write-through stores (single-cycle memory write)
//   * D-cache block fills
//   * I-cache block fills
// A block fill issues WORDS_PER_BLOCK pipelined word reads starting at the
// block-aligned base address. Returned words are streamed into the requesting
// cache's data array together with their word index. The last word also
// pulses the tag write for that cache.
//
// Arbitration in IDLE: a store always wins. Between the two fills, the D-cache
// is preferred unless the previous fill was also for the D-cache and the
// I-cache is waiting. That alternation keeps either cache from starving.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   i_miss / i_miss_addr         I-cache miss request and byte address
//   d_miss / d_miss_addr         D-cache miss request and byte address
//   d_wr_req / d_wr_addr / d_wr_data   write-through store request
//   mem_enable, mem_wr, mem_addr, mem_data_out   memory command
//   mem_data_in, mem_data_valid  memory read return
//   fill_data, fill_word         returned word and its index in the block
//   i_fill_we / d_fill_we        data-array write strobes
//   i_tag_we / d_tag_we          tag write pulse with the last word
//   i_busy / d_busy              a fill for that cache is in progress
//   wr_ack                       store performed this cycle
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_miss,
    input  logic [15:0]                        i_miss_addr,
    input  logic                               d_miss,
    input  logic [15:0]                        d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [15:0]                        d_wr_addr,
    input  logic [15:0]                        d_wr_data,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic [15:0]                        mem_addr,
    output logic [15:0]                        mem_data_out,
    input  logic [15:0]                        mem_data_in,
    input  logic                               mem_data_valid,
    output logic [15:0]                        fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic                               i_tag_we,
    output logic                               d_tag_we,
    output logic                               i_busy,
    output logic                               d_busy,
    output logic                               wr_ack
);

    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
    // One extra bit so the counters can hold the value "all words done".
    localparam int CNT_W  = WORD_W + 1;

    localparam logic [CNT_W-1:0] WPB_CNT   = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      BLOCK_BYTES = 16'(2 * WORDS_PER_BLOCK);
    localparam logic [15:0]      BASE_MASK   = ~(BLOCK_BYTES - 16'd1);

    // The memory latency only shapes when words come back; the receive side
    // is driven purely by mem_data_valid, so any latency >= 1 works.
    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 || CNT_W > 15) begin : g_param_check
        $error("cache_mem_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_D = 2'd2,
        ST_FILL_I = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   tx_r;          // reads issued in the current fill
    logic [CNT_W-1:0]   rx_r;          // words received in the current fill
    logic [15:0]        base_r;        // block-aligned fill address
    logic               last_fill_d_r; // 1: previous fill served the D-cache

    logic               filling_s;
    logic               issue_s;
    logic               rx_accept_s;
    logic               last_word_s;
    logic [15:0]        issue_offset_s;

    // Fill-progress decode shared by the sequencer and the output decode.
    always_comb begin
        filling_s      = (state_r == ST_FILL_D) || (state_r == ST_FILL_I);
        issue_s        = filling_s && (tx_r != WPB_CNT);
        rx_accept_s    = filling_s && mem_data_valid && (rx_r != WPB_CNT);
        last_word_s    = rx_accept_s && (rx_r == LAST_WORD);
        issue_offset_s = {{(15 - CNT_W){1'b0}}, tx_r, 1'b0};
    end

    // Arbitration state machine and fill counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            tx_r          <= '0;
            rx_r          <= '0;
            base_r        <= 16'h0000;
            last_fill_d_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r <= '0;
                    rx_r <= '0;
                    if (d_wr_req) begin
                        state_r <= ST_WRITE;
                    end else if (d_miss && !(last_fill_d_r && i_miss)) begin
                        state_r <= ST_FILL_D;
                        base_r  <= d_miss_addr & BASE_MASK;
                    end else if (i_miss) begin
                        state_r <= ST_FILL_I;
                        base_r  <= i_miss_addr & BASE_MASK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_r <= ST_IDLE;
                end
                ST_FILL_D, ST_FILL_I: begin
                    if (issue_s) begin
                        tx_r <= tx_r + CNT_ONE;
                    end else begin
                        tx_r <= tx_r;
                    end
                    if (rx_accept_s) begin
                        rx_r <= rx_r + CNT_ONE;
                    end else begin
                        rx_r <= rx_r;
                    end
                    // The fill ends on its last word even if the miss line
                    // was dropped meanwhile; a started fill never aborts.
                    if (last_word_s) begin
                        state_r       <= ST_IDLE;
                        last_fill_d_r <= (state_r == ST_FILL_D);
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from state and counters; fill_data is a direct path
    // from the memory so words land in the data array without extra delay.
    always_comb begin
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_out = 16'h0000;
        fill_data    = 16'h0000;
        fill_word    = '0;
        i_fill_we    = 1'b0;
        d_fill_we    = 1'b0;
        i_tag_we     = 1'b0;
        d_tag_we     = 1'b0;
        i_busy       = 1'b0;
        d_busy       = 1'b0;
        wr_ack       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_enable = 1'b0;
            end
            ST_WRITE: begin
                mem_enable   = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = d_wr_addr;
                mem_data_out = d_wr_data;
                wr_ack       = 1'b1;
            end
            ST_FILL_D, ST_FILL_I: begin
                if (issue_s) begin
                    mem_enable = 1'b1;
                    mem_addr   = base_r + issue_offset_s;
                end else begin
                    mem_enable = 1'b0;
                end
                fill_data = mem_data_in;
                if (rx_accept_s) begin
                    fill_word = rx_r[WORD_W-1:0];
                end else begin
                    fill_word = '0;
                end
                d_busy    = (state_r == ST_FILL_D);
                i_busy    = (state_r == ST_FILL_I);
                d_fill_we = rx_accept_s && (state_r == ST_FILL_D);
                i_fill_we = rx_accept_s && (state_r == ST_FILL_I);
                d_tag_we  = last_word_s && (state_r == ST_FILL_D);
                i_tag_we  = last_word_s && (state_r == ST_FILL_I);
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. A small behavioural memory with a
// 4-cycle read pipeline answers the fill reads. A vector table covers reset,
// store priority and fill entry; hand-written sequences cover full fills,
// round-robin between caches, a store held during a fill and a reset mid-fill.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_out, mem_data_in;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_busy, d_busy, wr_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.MEM_LATENCY(4), .WORDS_PER_BLOCK(8)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid), .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .i_tag_we(i_tag_we),
        .d_tag_we(d_tag_we), .i_busy(i_busy), .d_busy(d_busy), .wr_ack(wr_ack)
    );

    // Memory content: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Behavioural memory: reads return 4 cycles after issue; reset drops
    // in-flight reads; writes are recorded for checking.
    logic [3:0]  pv;
    logic [15:0] pa0, pa1, pa2, pa3;
    int          wr_cnt = 0;
    logic [15:0] wr_addr_seen = 16'h0000, wr_data_seen = 16'h0000;

    always @(posedge clk) begin
        if (rst) begin
            pv <= 4'b0000;
        end else begin
            pv  <= {pv[2:0], mem_enable & ~mem_wr};
            pa0 <= mem_addr;
            pa1 <= pa0;
            pa2 <= pa1;
            pa3 <= pa2;
            if (mem_enable && mem_wr) begin
                wr_cnt       <= wr_cnt + 1;
                wr_addr_seen <= mem_addr;
                wr_data_seen <= mem_data_out;
            end
        end
    end

    assign mem_data_valid = pv[3];
    assign mem_data_in    = pv[3] ? mem_word(pa3) : 16'h0000;

    logic [59:0] all_out;
    assign all_out = {mem_enable, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
                      i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_busy, d_busy, wr_ack};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one fill from an IDLE cycle c and checks cycles c+1..c+n_cyc.
    // drop_k: cycle after whose check the own miss line drops (0 = never).
    // wr_k: cycle after whose check a store request is raised (0 = never).
    // abort: assert rst after the last checked cycle.
    task automatic fill_seq(input bit is_d, input logic [15:0] addr, input int n_cyc,
                            input int drop_k, input int wr_k, input bit abort);
        logic [15:0] base;
        logic [15:0] e_addr;
        bit          e_en, e_we, e_tag, e_busy;
        string       tag;
        base = addr & 16'hFFF0;
        tag  = is_d ? "D" : "I";
        if (is_d) begin
            d_miss = 1'b1; d_miss_addr = addr;
        end else begin
            i_miss = 1'b1; i_miss_addr = addr;
        end
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            e_en   = (k <= 8);
            e_addr = e_en ? base + 16'(2 * (k - 1)) : 16'h0000;
            e_we   = (k >= 5) && (k <= 12);
            e_tag  = (k == 12);
            e_busy = (k <= 12);
            chk($sformatf("%s@%0h c+%0d mem_enable", tag, addr, k), 64'(mem_enable), 64'(e_en));
            chk($sformatf("%s@%0h c+%0d mem_addr", tag, addr, k), 64'(mem_addr), 64'(e_addr));
            chk($sformatf("%s@%0h c+%0d mem_wr/wr_ack", tag, addr, k), 64'({mem_wr, wr_ack}), 64'(0));
            chk($sformatf("%s@%0h c+%0d busy own/other", tag, addr, k),
                64'(is_d ? {d_busy, i_busy} : {i_busy, d_busy}), 64'({e_busy, 1'b0}));
            chk($sformatf("%s@%0h c+%0d fill_we own/other", tag, addr, k),
                64'(is_d ? {d_fill_we, i_fill_we} : {i_fill_we, d_fill_we}), 64'({e_we, 1'b0}));
            chk($sformatf("%s@%0h c+%0d tag_we own/other", tag, addr, k),
                64'(is_d ? {d_tag_we, i_tag_we} : {i_tag_we, d_tag_we}), 64'({e_tag, 1'b0}));
            if (e_we) begin
                chk($sformatf("%s@%0h c+%0d fill_word", tag, addr, k), 64'(fill_word), 64'(k - 5));
                chk($sformatf("%s@%0h c+%0d fill_data", tag, addr, k), 64'(fill_data),
                    64'(mem_word(base + 16'(2 * (k - 5)))));
            end
            if (k == drop_k) begin
                if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
            end
            if (k == wr_k) d_wr_req = 1'b1;
            if (abort && k == n_cyc) begin
                rst = 1'b1;
                if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        rst, wr, dm, im;      // inputs
        logic        en, mwr;              // expected outputs
        logic [15:0] addr, dout;
        logic        ack, dbusy, ibusy;
    } vec_t;

    vec_t vecs[8];
    int   wr_before;

    initial begin
        // Reset with every request high, store wins after release, then the
        // D fill (last_fill = I after reset) starts; reset again mid-issue.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A4, 16'hBEEF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4A50, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4A52, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

        d_wr_addr   = 16'h00A4;
        d_wr_data   = 16'hBEEF;
        d_miss_addr = 16'h4A5C;
        i_miss_addr = 16'h1236;

        for (int v = 0; v < 8; v++) begin
            rst      = vecs[v].rst;
            d_wr_req = vecs[v].wr;
            d_miss   = vecs[v].dm;
            i_miss   = vecs[v].im;
            @(negedge clk);
            chk($sformatf("vec%0d mem_enable", v), 64'(mem_enable), 64'(vecs[v].en));
            chk($sformatf("vec%0d mem_wr", v), 64'(mem_wr), 64'(vecs[v].mwr));
            chk($sformatf("vec%0d mem_addr", v), 64'(mem_addr), 64'(vecs[v].addr));
            chk($sformatf("vec%0d mem_data_out", v), 64'(mem_data_out), 64'(vecs[v].dout));
            chk($sformatf("vec%0d wr_ack", v), 64'(wr_ack), 64'(vecs[v].ack));
            chk($sformatf("vec%0d busy d/i", v), 64'({d_busy, i_busy}),
                64'({vecs[v].dbusy, vecs[v].ibusy}));
            chk($sformatf("vec%0d fill/tag we", v),
                64'({i_fill_we, d_fill_we, i_tag_we, d_tag_we}), 64'(0));
        end

        // Release reset and spend one idle cycle.
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset all outputs", 64'(all_out), 64'(0));

        // Both misses together: D first, then I, while D re-raised waits.
        i_miss = 1'b1; i_miss_addr = 16'h1236;
        fill_seq(1'b1, 16'h4A5C, 13, 12, 0, 1'b0);
        d_miss = 1'b1; d_miss_addr = 16'hFFFE;
        fill_seq(1'b0, 16'h1236, 13, 12, 0, 1'b0);
        fill_seq(1'b1, 16'hFFFE, 13, 12, 0, 1'b0);

        // Store raised during a D fill waits for the fill and one idle cycle.
        d_wr_addr = 16'h7776;
        d_wr_data = 16'h1357;
        wr_before = wr_cnt;
        fill_seq(1'b1, 16'h2468, 13, 12, 4, 1'b0);
        @(negedge clk);
        chk("held store wr_ack", 64'(wr_ack), 64'(1));
        chk("held store mem_en/wr", 64'({mem_enable, mem_wr}), 64'(2'b11));
        chk("held store mem_addr", 64'(mem_addr), 64'(16'h7776));
        chk("held store mem_data_out", 64'(mem_data_out), 64'(16'h1357));
        chk("held store busy/fill_we", 64'({d_busy, i_busy, d_fill_we, i_fill_we}), 64'(0));
        d_wr_req = 1'b0;
        @(negedge clk);
        chk("after store wr_ack", 64'(wr_ack), 64'(0));
        chk("after store mem_enable", 64'(mem_enable), 64'(0));
        chk("store write count", 64'(wr_cnt - wr_before), 64'(1));
        chk("store write addr", 64'(wr_addr_seen), 64'(16'h7776));
        chk("store write data", 64'(wr_data_seen), 64'(16'h1357));

        // Reset right after fill word 3 of an I fill.
        fill_seq(1'b0, 16'h5678, 8, 0, 0, 1'b1);
        @(negedge clk);
        chk("reset mid-fill all outputs", 64'(all_out), 64'(0));
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("post-reset quiet %0d", j),
                64'({mem_enable, i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_busy, d_busy}),
                64'(0));
        end
        fill_seq(1'b0, 16'h0F0E, 13, 12, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the I-cache and D-cache miss/write traffic onto the single shared multi-cycle main memory inside the memory interface. It serves three requesters:
- D-cache write-through stores.
- D-cache block fills.
- I-cache block fills.

Each fill is issued as 8 pipelined word reads, and the returned words are streamed into the requesting cache's data array with the word index.

## Interface
Parameters:
- MEM_LATENCY, 4, cycles from a memory read issue to its mem_data_valid
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (16-byte block)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset (memory shares it)
- i_miss  in  1  I-cache miss pending; held high until i_tag_we
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss pending; held high until d_tag_we
- d_miss_addr  in  16  D-cache miss byte address
- d_wr_req  in  1  write-through store pending; held high until wr_ack
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  memory write this cycle
- mem_addr  out  16  memory byte address
- mem_data_out  out  16  write data to memory
- mem_data_in  in  16  read data from memory
- mem_data_valid  in  1  mem_data_in valid this cycle
- fill_data  out  16  returned word (mem_data_in passthrough)
- fill_word  out  3  word index within block of fill_data
- i_fill_we / d_fill_we  out  1  write fill_data into I/D data array
- i_tag_we / d_tag_we  out  1  one-cycle pulse with last word: write tag, set valid
- i_busy / d_busy  out  1  fill in progress for I/D (feeds fsm_busy)
- wr_ack  out  1  one-cycle pulse: store performed

## Operation
- States: IDLE, WRITE, FILL_D, FILL_I.
- IDLE samples requests. Priority:
  - d_wr_req wins and goes to WRITE.
  - Otherwise, between fills, d_miss goes to FILL_D, unless last_fill==D and i_miss is high; in that case FILL_I.
  - i_miss alone goes to FILL_I.
  - last_fill updates at fill end.
- WRITE, one cycle:
  - mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_out=d_wr_data, wr_ack=1.
  - Next state IDLE.
- FILL_x entry:
  - Latch base = miss_addr & 16'hFFF0.
  - Issue counter tx=0, receive counter rx=0.
- FILL_x issue:
  - While tx<8: mem_enable=1, mem_wr=0, mem_addr=base + 2*tx, tx++.
  - tx saturates at 8; no further issues.
- FILL_x receive:
  - Each mem_data_valid with rx<8: x_fill_we=1, fill_word=rx, rx++.
  - mem_data_valid with rx==8, or in IDLE/WRITE, is ignored.
- FILL_x completion: the cycle receiving word 7 also asserts x_tag_we. Next state IDLE.
- x_busy=1 exactly while in FILL_x.
- A miss line deasserting mid-fill does not abort; the fill completes.
- Only the active cache's fill_we/tag_we may assert. Never both.
- rst at any time:
  - State goes to IDLE; tx, rx, last_fill (=I) clear.
  - All outputs 0 the cycle after the reset edge.
  - In-flight memory reads are discarded by the memory's own reset.

## Timing
- Reset values: every output 0, state IDLE, last_fill=I.
- Store: d_wr_req high in IDLE at cycle c → memory write and wr_ack in c+1 → IDLE at c+2.
- Fill: miss seen in IDLE at cycle c.
  - Busy from c+1.
  - Issues on c+1..c+8.
  - Words received on c+1+MEM_LATENCY .. c+8+MEM_LATENCY (c+5..c+12 at default).
  - tag_we at c+12; busy low and IDLE at c+13.
  - Earliest next request serviced c+14.
- A request arriving during a fill or write waits in the requester; it is evaluated in the next IDLE cycle.
- Simultaneous d_wr_req, d_miss, i_miss: store first, then D fill (last_fill=I after reset), then I fill.
- Outputs driven from state/counters combinationally. No extra register stage on fill_data.

## Test plan
- Reset: hold rst 2 cycles with all requests high → all outputs 0, first action after release is WRITE.
- I-fill, i_miss_addr=0x1236: mem_addr 0x1230..0x123E on c+1..c+8; fill_word 0..7 with i_fill_we c+5..c+12; i_tag_we at c+12 only; i_busy c+1..c+12.
- Store, d_wr_addr=0x00A4, data=0xBEEF: single memory write cycle with mem_wr=1, wr_ack one pulse, no fill_we.
- Simultaneous d_miss+i_miss held: D fill completes (d_tag_we), then I fill starts the cycle after IDLE. D miss re-raised during the I fill is not served until after I completes (round-robin).
- Store during D fill: d_wr_req held → wr_ack only after d_tag_we + 1 IDLE cycle; fill data uncorrupted.
- rst asserted at fill word 3: outputs 0 next cycle, no further fill_we/tag_we; a new i_miss afterwards completes a clean 8-word fill.
